// File: rtl/ram_access_ctrl.sv
// Burst initiator for the dual_port_ram pin interface: sequences setup/strobe/hold
// around a single-cycle wr pulse for writes and address/capture phases for reads.
module ram_access_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wr,
  output logic              ram_cs,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic [2:0] {
    IDLE, W_WAIT, W_SETUP, W_STROBE, W_HOLD, R_ADDR, R_CAP, DONE
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [LEN_W-1:0]   beats_left;
  logic               accept_c;
  logic               last_beat_c;
  logic               beat_end_c;

  assign req_ready   = (state == IDLE) && !rst;
  assign accept_c    = req_valid && req_ready;
  assign last_beat_c = (beats_left == '0);
  assign beat_end_c  = (state == W_HOLD) || (state == R_CAP);

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept_c) state_nx = req_wr ? W_WAIT : R_ADDR;
      W_WAIT:   if (wdata_valid) state_nx = W_SETUP;
      W_SETUP:  state_nx = W_STROBE;
      W_STROBE: state_nx = W_HOLD;
      W_HOLD:   state_nx = last_beat_c ? DONE : W_WAIT;
      R_ADDR:   state_nx = R_CAP;
      R_CAP:    state_nx = last_beat_c ? DONE : R_ADDR;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Pin and status flops are loaded from the next state so each output is a bare flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beats_left  <= '0;
      ram_addr    <= '0;
      ram_data    <= '0;
      ram_wr      <= 1'b0;
      ram_cs      <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      wdata_ready <= 1'b0;
    end else begin
      state       <= state_nx;
      ram_cs      <= (state_nx != IDLE) && (state_nx != DONE);
      ram_wr      <= (state_nx == W_STROBE);
      wdata_ready <= (state_nx == W_WAIT);
      busy        <= (state_nx != IDLE);
      done        <= (state_nx == DONE);
      rd_valid    <= (state == R_CAP);

      if (state == R_CAP) rd_data <= ram_out;

      if (state == W_WAIT && wdata_valid) ram_data <= wdata;

      // Address wraps modulo 2^ADDR_W between beats
      if (accept_c) begin
        ram_addr   <= req_addr;
        beats_left <= req_len;
      end else if (beat_end_c && !last_beat_c) begin
        ram_addr   <= ram_addr + ADDR_W'(1);
        beats_left <= beats_left - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: RAM model on the pins, transaction-level timing model
// checked every cycle, directed scenarios with literal expectations, then random bursts.
module tb_ram_access_ctrl;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 4;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          wdata_valid;
  logic          wdata_ready;
  logic [DW-1:0] wdata;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_wr;
  logic          ram_cs;
  logic [DW-1:0] ram_out;

  ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wr(ram_wr), .ram_cs(ram_cs),
    .ram_out(ram_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  function automatic void timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s cycle %0d: wait bound expired", nm, cyc);
  endfunction

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'((a * 37) + 90);
  endfunction

  // Environment RAM: level write while cs&&wr, combinational read
  logic [DW-1:0] ram [1024];
  assign ram_out = ram[ram_addr];
  always @(posedge clk) if (ram_cs && ram_wr) ram[ram_addr] = ram_data;

  // Reference model state
  typedef struct { int c; logic [DW-1:0] d; } rd_exp_t;
  logic [DW-1:0] m_mem [1024];
  rd_exp_t       rd_q[$];
  bit            model_on = 0;
  bit            after_rst = 0;
  bit            m_act = 0;
  bit            m_wr = 0;
  logic [AW-1:0] m_base = '0;
  logic [DW-1:0] m_data = '0;
  int            m_n = 0, m_k = 0, m_first = 0, m_acc = -1, m_done = -1;

  // Observed statistics for the directed literal checks
  int            wr_pulses = 0, done_cnt = 0, rd_cnt = 0, busy_cnt = 0;
  int            last_wr_cyc = 0, last_done_cyc = 0, acc_cyc = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [DW-1:0] last_wr_data = '0, last_rd_data = '0;
  int            rd_cycles[$];
  logic [DW-1:0] rd_vals[$];

  // Write-data source
  logic [DW-1:0] wq[$];
  bit            wfire = 0;
  int            wstall_pct = 0;
  int            wstall_hold = 0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]   = init_val(i);
      m_mem[i] = init_val(i);
    end
  end

  initial begin
    wdata_valid = 1'b0;
    wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (wfire && wq.size() > 0) void'(wq.pop_front());
      wfire = 0;
      if (wstall_hold > 0) wstall_hold--;
      if (wq.size() > 0 && wstall_hold == 0 && int'($urandom_range(99)) >= wstall_pct) begin
        wdata_valid = 1'b1;
        wdata = wq[0];
      end else begin
        wdata_valid = 1'b0;
        wdata = DW'($urandom);
      end
    end
  end

  // Compare against the model for the current cycle, then advance it across the next edge
  always @(negedge clk) begin
    logic          e_cs, e_wr, e_wrdy, e_rv, addr_chk, data_chk;
    logic [AW-1:0] e_addr;
    int            x;
    cyc++;
    x = cyc;
    e_cs = 0; e_wr = 0; e_wrdy = 0; e_rv = 0; addr_chk = 0; data_chk = 0; e_addr = '0;

    if (model_on) begin
      if (m_act && x != m_done) begin
        e_cs = 1'b1;
        addr_chk = 1'b1;
        if (!m_wr) e_addr = AW'(int'(m_base) + (x - m_first) / 2);
        else begin
          e_addr = AW'(int'(m_base) + m_k);
          if (m_acc < 0) e_wrdy = 1'b1;
          else begin
            e_wr = (x == m_acc + 2);
            data_chk = 1'b1;
          end
        end
      end
      chk("busy", 32'(busy), 32'(m_act));
      chk("req_ready", 32'(req_ready), 32'(!m_act && !rst));
      chk("done", 32'(done), 32'(m_act && x == m_done));
      chk("ram_cs", 32'(ram_cs), 32'(e_cs));
      chk("ram_wr", 32'(ram_wr), 32'(e_wr));
      chk("wdata_ready", 32'(wdata_ready), 32'(e_wrdy));
      if (addr_chk) chk("ram_addr", 32'(ram_addr), 32'(e_addr));
      if (data_chk) chk("ram_data", 32'(ram_data), 32'(m_data));
      e_rv = (rd_q.size() > 0) && (rd_q[0].c == x);
      chk("rd_valid", 32'(rd_valid), 32'(e_rv));
      if (e_rv) begin
        chk("rd_data", 32'(rd_data), 32'(rd_q[0].d));
        void'(rd_q.pop_front());
      end
      if (after_rst) begin
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_ram_data", 32'(ram_data), 32'h0);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
      end
    end

    if (ram_wr === 1'b1) begin
      wr_pulses++; last_wr_cyc = x; last_wr_addr = ram_addr; last_wr_data = ram_data;
    end
    if (done === 1'b1) begin done_cnt++; last_done_cyc = x; end
    if (rd_valid === 1'b1) begin
      rd_cnt++; rd_cycles.push_back(x); rd_vals.push_back(rd_data); last_rd_data = rd_data;
    end
    if (busy === 1'b1) busy_cnt++;
    if (req_valid && req_ready === 1'b1) acc_cyc = x + 1;
    if (wdata_valid && wdata_ready === 1'b1) wfire = 1;

    // A strobe cycle commits its word at the closing edge, even if reset arrives there
    if (m_act && m_wr && m_acc >= 0 && x == m_acc + 2)
      m_mem[AW'(int'(m_base) + m_k)] = m_data;

    if (rst) begin
      m_act = 0;
      rd_q.delete();
      after_rst = 1;
      model_on = 1;
    end else if (model_on) begin
      after_rst = 0;
      if (!m_act) begin
        if (req_valid) begin
          m_act = 1; m_wr = req_wr; m_base = req_addr; m_n = int'(req_len) + 1;
          m_k = 0; m_first = x + 1; m_acc = -1; m_done = -1;
          if (!req_wr) begin
            m_done = m_first + 2 * m_n;
            for (int k = 0; k < m_n; k++)
              rd_q.push_back('{c: m_first + 2 + 2 * k, d: m_mem[AW'(int'(m_base) + k)]});
          end
        end
      end else if (x == m_done) begin
        m_act = 0;
      end else if (m_wr) begin
        if (m_acc < 0) begin
          if (wdata_valid) begin m_acc = x; m_data = wdata; end
        end else if (x == m_acc + 3) begin
          m_k++;
          if (m_k == m_n) m_done = x + 1;
          else m_acc = -1;
        end
      end
    end
  end

  task automatic do_cmd(input bit w, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = w; req_addr = a; req_len = l;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      if (++n > 3000) begin timeout_fail("cmd_accept"); break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy) begin
      @(negedge clk);
      if (++n > 3000) begin timeout_fail("wait_idle"); break; end
    end
    @(negedge clk);
  endtask

  initial begin
    int w0, d0, r0, b0, n, seen;
    logic [DW-1:0] exp4 [4];
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);

    // Single write then read-back
    wstall_pct = 0;
    wq.push_back(8'hA5);
    w0 = wr_pulses;
    do_cmd(1'b1, 10'h005, 4'd0);
    wait_idle();
    chk("w1_wr_pulses", 32'(wr_pulses - w0), 32'd1);
    chk("w1_strobe_cycle", 32'(last_wr_cyc - acc_cyc), 32'd2);
    chk("w1_done_cycle", 32'(last_done_cyc - acc_cyc), 32'd4);
    chk("w1_wr_addr", 32'(last_wr_addr), 32'h005);
    chk("w1_wr_data", 32'(last_wr_data), 32'hA5);
    do_cmd(1'b0, 10'h005, 4'd0);
    wait_idle();
    chk("r1_data", 32'(last_rd_data), 32'hA5);

    // Wrapping write burst and read-back
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) wq.push_back(exp4[i]);
    do_cmd(1'b1, 10'h3FE, 4'd3);
    wait_idle();
    chk("wrap_mem_3fe", 32'(ram[10'h3FE]), 32'h11);
    chk("wrap_mem_3ff", 32'(ram[10'h3FF]), 32'h22);
    chk("wrap_mem_000", 32'(ram[10'h000]), 32'h33);
    chk("wrap_mem_001", 32'(ram[10'h001]), 32'h44);
    rd_cycles.delete(); rd_vals.delete();
    do_cmd(1'b0, 10'h3FE, 4'd3);
    wait_idle();
    chk("wrap_rd_count", 32'(rd_vals.size()), 32'd4);
    if (rd_vals.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("wrap_rd_val", 32'(rd_vals[i]), 32'(exp4[i]));
        if (i > 0) chk("wrap_rd_spacing", 32'(rd_cycles[i] - rd_cycles[i-1]), 32'd2);
      end

    // Stalled write data
    w0 = wr_pulses;
    wq.push_back(8'h6E); wq.push_back(8'h7F);
    wstall_hold = 6;
    do_cmd(1'b1, 10'h100, 4'd1);
    wait_idle();
    chk("stall_wr_pulses", 32'(wr_pulses - w0), 32'd2);
    chk("stall_mem_100", 32'(ram[10'h100]), 32'h6E);
    chk("stall_mem_101", 32'(ram[10'h101]), 32'h7F);

    // Request held while busy
    d0 = done_cnt;
    wq.push_back(8'h5C);
    do_cmd(1'b1, 10'h200, 4'd0);
    do_cmd(1'b0, 10'h200, 4'd0);
    wait_idle();
    chk("busy_done_count", 32'(done_cnt - d0), 32'd2);
    chk("busy_rd_data", 32'(last_rd_data), 32'h5C);

    // Reset during second strobe of a four-beat write
    d0 = done_cnt;
    wq.push_back(8'hC1); wq.push_back(8'hC2); wq.push_back(8'hC3); wq.push_back(8'hC4);
    do_cmd(1'b1, 10'h300, 4'd3);
    n = 0; seen = 0;
    while (seen < 2) begin
      @(posedge clk); #2;
      if (ram_wr) seen++;
      if (++n > 500) begin timeout_fail("rst_wait_strobe"); break; end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wq.delete(); wfire = 0;
    repeat (4) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_mem_300", 32'(ram[10'h300]), 32'hC1);
    chk("rst_mem_301", 32'(ram[10'h301]), 32'hC2);
    chk("rst_mem_302", 32'(ram[10'h302]), 32'(init_val(10'h302)));
    chk("rst_mem_303", 32'(ram[10'h303]), 32'(init_val(10'h303)));
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Longest read burst
    r0 = rd_cnt; d0 = done_cnt; b0 = busy_cnt;
    do_cmd(1'b0, 10'h000, 4'd15);
    wait_idle();
    chk("max_rd_count", 32'(rd_cnt - r0), 32'd16);
    chk("max_done_count", 32'(done_cnt - d0), 32'd1);
    chk("max_busy_cycles", 32'(busy_cnt - b0), 32'd33);

    // Random bursts
    for (int t = 0; t < 40; t++) begin
      bit            w;
      logic [LW-1:0] l;
      w = 1'($urandom);
      l = LW'($urandom);
      wstall_pct = int'($urandom_range(60));
      if (w) for (int i = 0; i <= int'(l); i++) wq.push_back(DW'($urandom));
      do_cmd(w, AW'($urandom), l);
      wait_idle();
    end

    n = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== m_mem[i]) n++;
    chk("ram_vs_model_diffs", 32'(n), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
